// File: rtl/half_adder_sync_pkg.sv
// Shared types and the single-lane half-adder equation used by the datapath.
package half_adder_sync_pkg;

  // Result of one half-adder lane.
  typedef struct packed {
    logic carry;
    logic sum;
  } ha_lane_t;

  // One-lane half adder: sum is the XOR, carry is the AND.
  function automatic ha_lane_t ha_eval(input logic a, input logic b);
    ha_lane_t r;
    r.sum   = a ^ b;
    r.carry = a & b;
    return r;
  endfunction

endpackage

// File: rtl/half_adder_bit.sv
// One-bit combinational half-adder cell; no clock, no reset, no state.
module half_adder_bit
  import half_adder_sync_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic carry_o
);

  ha_lane_t lane;

  // Pure combinational evaluation of the lane.
  always_comb begin
    lane    = ha_eval(a_i, b_i);
    sum_o   = lane.sum;
    carry_o = lane.carry;
  end

endmodule

// File: rtl/half_adder_sync.sv
// WIDTH-lane half adder with zero-latency outputs and a one-cycle registered copy.
// Lanes are independent; carries never ripple between lanes here.
module half_adder_sync
  import half_adder_sync_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic [WIDTH-1:0] carry_o,
  output logic [WIDTH-1:0] sum_q_o,
  output logic [WIDTH-1:0] carry_q_o
);

  // Stage 0: combinational lanes, independent of clk_i/rst_i.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_bit u_bit (
      .a_i     (a_i[i]),
      .b_i     (b_i[i]),
      .sum_o   (sum_o[i]),
      .carry_o (carry_o[i])
    );
  end

  // Stage 1: register the combinational results; synchronous clear has priority.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q_o   <= '0;
      carry_q_o <= '0;
    end else begin
      sum_q_o   <= sum_o;
      carry_q_o <= carry_o;
    end
  end

endmodule

// File: tb/tb_half_adder_sync.sv
module tb_half_adder_sync;

  logic       clk;
  logic       clk_en;
  logic       rst;
  logic       a1, b1;
  logic [3:0] a4, b4;
  logic       s1, c1, sq1, cq1;
  logic [3:0] s4, c4, sq4, cq4;

  int n_cmp;
  int n_bad;

  // expected registered values, computed before each edge
  logic [3:0] exp_sq4, exp_cq4;
  logic       exp_sq1, exp_cq1;

  half_adder_sync #(.WIDTH(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .a_i(a1), .b_i(b1),
    .sum_o(s1), .carry_o(c1), .sum_q_o(sq1), .carry_q_o(cq1)
  );

  half_adder_sync #(.WIDTH(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .a_i(a4), .b_i(b4),
    .sum_o(s4), .carry_o(c4), .sum_q_o(sq4), .carry_q_o(cq4)
  );

  initial clk = 1'b0;
  always #5 clk = clk_en ? ~clk : 1'b0;

  typedef struct {
    logic a;
    logic b;
    logic sum;
    logic carry;
  } vec_t;

  vec_t tbl [4];

  // Reference: each lane is a 1-bit addition; the 2-bit result is {carry,sum}.
  function automatic logic [7:0] ref_add(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] s, c;
    int t;
    s = '0;
    c = '0;
    for (int i = 0; i < 4; i++) begin
      t    = int'(a[i]) + int'(b[i]);
      s[i] = (t % 2) != 0;
      c[i] = (t / 2) != 0;
    end
    return {c, s};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare combinational outputs of both instances against the reference.
  task automatic check_comb(input string name);
    logic [7:0] r1, r4;
    r1 = ref_add({3'b0, a1}, {3'b0, b1});
    r4 = ref_add(a4, b4);
    check({name, "_s1"}, {7'b0, s1}, {7'b0, r1[0]});
    check({name, "_c1"}, {7'b0, c1}, {7'b0, r1[4]});
    check({name, "_s4"}, {4'b0, s4}, {4'b0, r4[3:0]});
    check({name, "_c4"}, {4'b0, c4}, {4'b0, r4[7:4]});
  endtask

  // Predict the registered result from current inputs/reset, clock once, compare.
  task automatic tick(input string name);
    logic [7:0] r1, r4;
    r1 = ref_add({3'b0, a1}, {3'b0, b1});
    r4 = ref_add(a4, b4);
    exp_sq1 = rst ? 1'b0 : r1[0];
    exp_cq1 = rst ? 1'b0 : r1[4];
    exp_sq4 = rst ? 4'b0 : r4[3:0];
    exp_cq4 = rst ? 4'b0 : r4[7:4];
    @(posedge clk);
    #1;
    check({name, "_sq1"}, {7'b0, sq1}, {7'b0, exp_sq1});
    check({name, "_cq1"}, {7'b0, cq1}, {7'b0, exp_cq1});
    check({name, "_sq4"}, {4'b0, sq4}, {4'b0, exp_sq4});
    check({name, "_cq4"}, {4'b0, cq4}, {4'b0, exp_cq4});
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    clk_en = 1'b0;
    rst    = 1'b0;
    a1 = 1'b0; b1 = 1'b0; a4 = '0; b4 = '0;

    tbl[0] = '{a: 1'b0, b: 1'b0, sum: 1'b0, carry: 1'b0};
    tbl[1] = '{a: 1'b0, b: 1'b1, sum: 1'b1, carry: 1'b0};
    tbl[2] = '{a: 1'b1, b: 1'b0, sum: 1'b1, carry: 1'b0};
    tbl[3] = '{a: 1'b1, b: 1'b1, sum: 1'b0, carry: 1'b1};

    // exhaustive truth table with the clock idle
    for (int i = 0; i < 4; i++) begin
      a1 = tbl[i].a;
      b1 = tbl[i].b;
      #0;
      check($sformatf("tt%0d_sum", i),   {7'b0, s1}, {7'b0, tbl[i].sum});
      check($sformatf("tt%0d_carry", i), {7'b0, c1}, {7'b0, tbl[i].carry});
      #10;
    end

    // reset held for two edges with a=b=1
    clk_en = 1'b1;
    rst = 1'b1; a1 = 1'b1; b1 = 1'b1; a4 = 4'hF; b4 = 4'hF;
    for (int k = 0; k < 2; k++) begin
      tick("rst");
      check("rst_comb_s1", {7'b0, s1}, 8'h00);
      check("rst_comb_c1", {7'b0, c1}, 8'h01);
      check("rst_sq1", {7'b0, sq1}, 8'h00);
      check("rst_cq1", {7'b0, cq1}, 8'h00);
    end

    // latency: release reset and present a=1,b=0 before edge N
    rst = 1'b0; a1 = 1'b1; b1 = 1'b0;
    #1;
    check("lat_before_sq1", {7'b0, sq1}, 8'h00);
    check("lat_comb_s1", {7'b0, s1}, 8'h01);
    tick("lat");
    check("lat_after_sq1", {7'b0, sq1}, 8'h01);
    check("lat_after_cq1", {7'b0, cq1}, 8'h00);

    // mid-stream reset between 11 and 01
    a1 = 1'b1; b1 = 1'b1;
    tick("ms_11");
    check("ms_11_cq1", {7'b0, cq1}, 8'h01);
    rst = 1'b1;
    tick("ms_rst");
    check("ms_rst_sq1", {7'b0, sq1}, 8'h00);
    check("ms_rst_cq1", {7'b0, cq1}, 8'h00);
    check("ms_rst_comb_c1", {7'b0, c1}, 8'h01);
    rst = 1'b0; a1 = 1'b0; b1 = 1'b1;
    #1;
    check("ms_01_comb_s1", {7'b0, s1}, 8'h01);
    tick("ms_01");
    check("ms_01_sq1", {7'b0, sq1}, 8'h01);

    // multi-lane vector
    a4 = 4'b1100; b4 = 4'b1010;
    #0;
    check("ml_s4", {4'b0, s4}, 8'h06);
    check("ml_c4", {4'b0, c4}, 8'h08);
    tick("ml");
    check("ml_sq4", {4'b0, sq4}, 8'h06);
    check("ml_cq4", {4'b0, cq4}, 8'h08);

    // reset glitch entirely between edges
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("gl_mid_sq4", {4'b0, sq4}, 8'h06);
    check("gl_mid_cq4", {4'b0, cq4}, 8'h08);
    check("gl_mid_sq1", {7'b0, sq1}, 8'h01);
    tick("gl");
    check("gl_after_sq4", {4'b0, sq4}, 8'h06);

    // randomized stream with occasional reset
    for (int n = 0; n < 300; n++) begin
      a1  = 1'($urandom);
      b1  = 1'($urandom);
      a4  = 4'($urandom);
      b4  = 4'($urandom);
      rst = ($urandom_range(0, 7) == 0);
      #1;
      check_comb("rnd");
      tick("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
